// File: rtl/blackjack_pkg.sv
// ============================================================================
//  Module   : blackjack_pkg
//  Purpose  : Shared state encoding, outcome codes and game constants for the
//             Blackjack round sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package blackjack_pkg;

    // Round sequencer states
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_DEAL_P1     = 4'd1,
        ST_DEAL_D1     = 4'd2,
        ST_DEAL_P2     = 4'd3,
        ST_DEAL_D2     = 4'd4,
        ST_PLAYER_TURN = 4'd5,
        ST_PLAYER_DRAW = 4'd6,
        ST_DEALER_TURN = 4'd7,
        ST_DEALER_DRAW = 4'd8,
        ST_RESOLVE     = 4'd9,
        ST_DONE        = 4'd10
    } bj_state_e;

    // Round outcome codes
    localparam logic [1:0] OUT_NONE   = 2'b00;
    localparam logic [1:0] OUT_PLAYER = 2'b01;
    localparam logic [1:0] OUT_DEALER = 2'b10;
    localparam logic [1:0] OUT_PUSH   = 2'b11;

    // Game constants
    localparam int BJ_LIMIT     = 21;
    localparam int DEALER_STAND = 17;
    localparam int ACE_BONUS    = 10;

endpackage : blackjack_pkg

`default_nettype wire

// File: rtl/bj_hand_acc.sv
// ============================================================================
//  Module   : bj_hand_acc
//  Purpose  : One Blackjack hand. Accumulates clamped card values, tracks an
//             ace and produces the hard sum, effective sum and soft flag,
//             all registered.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bj_hand_acc
    import blackjack_pkg::*;
#(
    parameter int CARD_W = 4,
    parameter int SUM_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              add_i,
    input  logic [CARD_W-1:0] value_i,
    output logic [SUM_W-1:0]  hard_o,
    output logic [SUM_W-1:0]  eff_o,
    output logic              soft_o
);

    logic [CARD_W-1:0] w_value;
    logic [SUM_W-1:0]  hard_q, hard_d;
    logic [SUM_W-1:0]  eff_q, eff_d;
    logic              ace_q, ace_d;
    logic              soft_q, soft_d;

    // Next hand value: clamp the card, add it, then decide whether the ace counts as 11
    always_comb begin
        w_value = value_i;
        if (value_i == '0 || value_i > CARD_W'(10)) begin
            w_value = CARD_W'(10);
        end
        hard_d = hard_q;
        ace_d  = ace_q;
        if (clear_i) begin
            hard_d = '0;
            ace_d  = 1'b0;
        end else if (add_i) begin
            hard_d = hard_q + SUM_W'(w_value);
            ace_d  = ace_q | (w_value == CARD_W'(1));
        end
        soft_d = ace_d && (hard_d <= SUM_W'(BJ_LIMIT - ACE_BONUS));
        eff_d  = soft_d ? (hard_d + SUM_W'(ACE_BONUS)) : hard_d;
    end

    // Hand registers; effective sum and soft flag are stored with the hard sum
    always_ff @(posedge clk) begin
        if (rst) begin
            hard_q <= '0;
            eff_q  <= '0;
            ace_q  <= 1'b0;
            soft_q <= 1'b0;
        end else begin
            hard_q <= hard_d;
            eff_q  <= eff_d;
            ace_q  <= ace_d;
            soft_q <= soft_d;
        end
    end

    assign hard_o = hard_q;
    assign eff_o  = eff_q;
    assign soft_o = soft_q;

endmodule : bj_hand_acc

`default_nettype wire

// File: rtl/blackjack_round_ctrl.sv
// ============================================================================
//  Module   : blackjack_round_ctrl
//  Purpose  : Blackjack round sequencer. Edge-detects the buttons, deals four
//             cards over a req/valid handshake, runs player hit/stand and the
//             dealer draw-to-17 policy, and latches the round outcome.
//  Options  : BJ_DEALER_HIT_SOFT17_EN - when defined the dealer also draws on
//             a soft 17; otherwise the dealer stands on every 17.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module blackjack_round_ctrl
    import blackjack_pkg::*;
#(
    parameter int CARD_W = 4,
    parameter int SUM_W  = 5
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              deal_btn,
    input  logic              hit_btn,
    input  logic              stand_btn,
    output logic              card_req,
    input  logic              card_valid,
    input  logic [CARD_W-1:0] card_value,
    output logic [SUM_W-1:0]  player_sum,
    output logic [SUM_W-1:0]  dealer_sum,
    output logic              player_soft,
    output logic              player_turn,
    output logic [1:0]        outcome,
    output logic              round_done
);

`ifdef BJ_DEALER_HIT_SOFT17_EN
    localparam bit HIT_SOFT17 = 1'b1;
`else
    localparam bit HIT_SOFT17 = 1'b0;
`endif

    bj_state_e        state_q;
    logic             card_req_q, player_turn_q, round_done_q;
    logic [1:0]       outcome_q;
    logic             deal_q, hit_q, stand_q;
    logic             deal_press_q, hit_press_q, stand_press_q;

    logic             w_xfer, w_clear, w_p_add, w_d_add, w_dealer_draw;
    logic [1:0]       w_outcome;
    logic [SUM_W-1:0] w_p_hard, w_p_eff, w_d_hard, w_d_eff;
    logic             w_p_soft, w_d_soft;

    // Button edge detection; the press pulse is registered before the FSM sees it
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            deal_q        <= 1'b0;
            hit_q         <= 1'b0;
            stand_q       <= 1'b0;
            deal_press_q  <= 1'b0;
            hit_press_q   <= 1'b0;
            stand_press_q <= 1'b0;
        end else begin
            deal_q        <= deal_btn;
            hit_q         <= hit_btn;
            stand_q       <= stand_btn;
            deal_press_q  <= deal_btn && !deal_q;
            hit_press_q   <= hit_btn && !hit_q;
            stand_press_q <= stand_btn && !stand_q;
        end
    end

    // Hand control decode: which hand takes the transferring card, and new-round clear
    always_comb begin
        w_xfer  = card_req_q && card_valid;
        w_clear = deal_press_q && (state_q == ST_IDLE || state_q == ST_DONE);
        w_p_add = w_xfer && (state_q == ST_DEAL_P1 || state_q == ST_DEAL_P2 ||
                             state_q == ST_PLAYER_DRAW);
        w_d_add = w_xfer && (state_q == ST_DEAL_D1 || state_q == ST_DEAL_D2 ||
                             state_q == ST_DEALER_DRAW);
    end

    bj_hand_acc #(.CARD_W(CARD_W), .SUM_W(SUM_W)) u_player_hand (
        .clk     (CLOCK_50),
        .rst     (reset),
        .clear_i (w_clear),
        .add_i   (w_p_add),
        .value_i (card_value),
        .hard_o  (w_p_hard),
        .eff_o   (w_p_eff),
        .soft_o  (w_p_soft)
    );

    bj_hand_acc #(.CARD_W(CARD_W), .SUM_W(SUM_W)) u_dealer_hand (
        .clk     (CLOCK_50),
        .rst     (reset),
        .clear_i (w_clear),
        .add_i   (w_d_add),
        .value_i (card_value),
        .hard_o  (w_d_hard),
        .eff_o   (w_d_eff),
        .soft_o  (w_d_soft)
    );

    // Dealer policy and outcome decision; bust is judged on the hard sum since eff never exceeds 21 via the ace bonus
    always_comb begin
        w_dealer_draw = (w_d_eff < SUM_W'(DEALER_STAND)) ||
                        (HIT_SOFT17 && w_d_soft && (w_d_eff == SUM_W'(DEALER_STAND)));
        if (w_p_hard > SUM_W'(BJ_LIMIT)) begin
            w_outcome = OUT_DEALER;
        end else if (w_d_hard > SUM_W'(BJ_LIMIT)) begin
            w_outcome = OUT_PLAYER;
        end else if (w_p_eff > w_d_eff) begin
            w_outcome = OUT_PLAYER;
        end else if (w_d_eff > w_p_eff) begin
            w_outcome = OUT_DEALER;
        end else begin
            w_outcome = OUT_PUSH;
        end
    end

    // Round FSM; a card state holds card_req until the transfer, then advances on the following cycle
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            card_req_q    <= 1'b0;
            player_turn_q <= 1'b0;
            outcome_q     <= OUT_NONE;
            round_done_q  <= 1'b0;
        end else begin
            player_turn_q <= 1'b0;
            if (w_xfer) begin
                card_req_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (deal_press_q) begin
                        state_q    <= ST_DEAL_P1;
                        card_req_q <= 1'b1;
                    end
                end
                ST_DEAL_P1: begin
                    if (!card_req_q) begin
                        state_q    <= ST_DEAL_D1;
                        card_req_q <= 1'b1;
                    end
                end
                ST_DEAL_D1: begin
                    if (!card_req_q) begin
                        state_q    <= ST_DEAL_P2;
                        card_req_q <= 1'b1;
                    end
                end
                ST_DEAL_P2: begin
                    if (!card_req_q) begin
                        state_q    <= ST_DEAL_D2;
                        card_req_q <= 1'b1;
                    end
                end
                ST_DEAL_D2: begin
                    if (!card_req_q) begin
                        if (w_p_eff == SUM_W'(BJ_LIMIT)) begin
                            state_q <= ST_DEALER_TURN;
                        end else begin
                            state_q       <= ST_PLAYER_TURN;
                            player_turn_q <= 1'b1;
                        end
                    end
                end
                ST_PLAYER_TURN: begin
                    if (stand_press_q) begin
                        state_q <= ST_DEALER_TURN;
                    end else if (hit_press_q) begin
                        state_q    <= ST_PLAYER_DRAW;
                        card_req_q <= 1'b1;
                    end else begin
                        player_turn_q <= 1'b1;
                    end
                end
                ST_PLAYER_DRAW: begin
                    if (!card_req_q) begin
                        if (w_p_hard > SUM_W'(BJ_LIMIT)) begin
                            state_q <= ST_RESOLVE;
                        end else if (w_p_eff == SUM_W'(BJ_LIMIT)) begin
                            state_q <= ST_DEALER_TURN;
                        end else begin
                            state_q       <= ST_PLAYER_TURN;
                            player_turn_q <= 1'b1;
                        end
                    end
                end
                ST_DEALER_TURN: begin
                    if (w_dealer_draw) begin
                        state_q    <= ST_DEALER_DRAW;
                        card_req_q <= 1'b1;
                    end else begin
                        state_q <= ST_RESOLVE;
                    end
                end
                ST_DEALER_DRAW: begin
                    if (!card_req_q) begin
                        state_q <= ST_DEALER_TURN;
                    end
                end
                ST_RESOLVE: begin
                    outcome_q    <= w_outcome;
                    round_done_q <= 1'b1;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    if (deal_press_q) begin
                        outcome_q    <= OUT_NONE;
                        round_done_q <= 1'b0;
                        state_q      <= ST_DEAL_P1;
                        card_req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    card_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign card_req    = card_req_q;
    assign player_sum  = w_p_eff;
    assign dealer_sum  = w_d_eff;
    assign player_soft = w_p_soft;
    assign player_turn = player_turn_q;
    assign outcome     = outcome_q;
    assign round_done  = round_done_q;

endmodule : blackjack_round_ctrl

`default_nettype wire
